// File: rtl/fxp_divider_if.sv
// Start/busy/done handshake bundle between the fixed-point unit and the divider.
interface fxp_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, div_by_zero, overflow
    );
endinterface

// File: rtl/fxp_divider.sv
// Sequential signed fixed-point divider: quotient = (dividend << FBITS) / divisor,
// one radix-2 restoring step per cycle, saturating on overflow and divide-by-zero.
module fxp_divider #(
    parameter int WIDTH = 32,
    parameter int FBITS = 10
) (
    input  logic          clk,
    input  logic          reset,
    fxp_divider_if.slave  bus
);
    localparam int QW = WIDTH + FBITS;
    localparam int CW = $clog2(QW);
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_PREP, S_ITER, S_FIX} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, dvs_q, dvs_d;
    logic [QW-1:0]    num_q, num_d, quo_q, quo_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_q, neg_d, zero_q, zero_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             done_q, done_d, dbz_q, dbz_d, ovf_q, ovf_d;

    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH+1:0] rem_shift;
    logic             ge;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        dvs_d   = dvs_q;
        num_d   = num_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        zero_d  = zero_q;
        res_d   = res_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;

        // The most-negative input negates to itself, which reads correctly as 2^(WIDTH-1) unsigned.
        a_abs     = a_q[WIDTH-1] ? -a_q : a_q;
        b_abs     = b_q[WIDTH-1] ? -b_q : b_q;
        rem_shift = {rem_q, num_q[QW-1]};
        ge        = (rem_shift >= {2'b00, dvs_q});

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.dividend;
                    b_d     = bus.divisor;
                    dbz_d   = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                neg_d  = a_q[WIDTH-1] ^ b_q[WIDTH-1];
                dvs_d  = b_abs;
                zero_d = (b_q == '0);
                if (b_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    num_d   = QW'(a_abs) << FBITS;
                    rem_d   = '0;
                    quo_d   = '0;
                    cnt_d   = '0;
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                num_d = num_q << 1;
                rem_d = (WIDTH+1)'(ge ? (rem_shift - {2'b00, dvs_q}) : rem_shift);
                quo_d = {quo_q[QW-2:0], ge};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(QW-1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                done_d  = 1'b1;
                dbz_d   = zero_q;
                ovf_d   = 1'b0;
                state_d = S_IDLE;
                if (zero_q) begin
                    if (a_q == '0)        res_d = '0;
                    else if (a_q[WIDTH-1]) res_d = MIN_NEG;
                    else                   res_d = MAX_POS;
                end else if (!neg_q) begin
                    if (quo_q > QW'(MAX_POS)) begin
                        res_d = MAX_POS;
                        ovf_d = 1'b1;
                    end else begin
                        res_d = quo_q[WIDTH-1:0];
                    end
                end else begin
                    // Negative side can reach one step further than positive.
                    if (quo_q > QW'(MIN_NEG)) begin
                        res_d = MIN_NEG;
                        ovf_d = 1'b1;
                    end else begin
                        res_d = -quo_q[WIDTH-1:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            dvs_q   <= '0;
            num_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            zero_q  <= 1'b0;
            res_q   <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            dvs_q   <= dvs_d;
            num_q   <= num_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            zero_q  <= zero_d;
            res_q   <= res_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = done_q;
    assign bus.quotient    = res_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_fxp_divider.sv
// Bench for fxp_divider: directed and random divides against a plain-arithmetic
// reference, plus handshake, back-to-back and mid-operation reset scenarios.
module tb_fxp_divider;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fxp_divider_if #(.WIDTH(32)) bus();
    fxp_divider #(.WIDTH(32), .FBITS(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Returns {div_by_zero, overflow, quotient}.
    function automatic logic [33:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, r;
        logic [31:0] q;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        if (sb == 0) begin
            if (sa > 0)      q = 32'h7FFF_FFFF;
            else if (sa < 0) q = 32'h8000_0000;
            else             q = 32'h0;
            return {1'b1, 1'b0, q};
        end
        r = (sa * 1024) / sb;  // SV integer division truncates toward zero
        if (r > 64'sd2147483647)  return {2'b01, 32'h7FFF_FFFF};
        if (r < -64'sd2147483648) return {2'b01, 32'h8000_0000};
        q = r[31:0];
        return {2'b00, q};
    endfunction

    task automatic wait_done(output int lat, output logic busy_ok);
        lat     = -1;
        busy_ok = bus.busy;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                lat = i;
                break;
            end
            if (!bus.busy) busy_ok = 1'b0;
        end
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [33:0] e;
        int          lat;
        logic        busy_ok;
        e = ref_div(a, b);
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(lat, busy_ok);
        check({tag, " latency"}, 64'(lat), (b == 32'h0) ? 64'd2 : 64'd44);
        check({tag, " quotient"}, 64'(bus.quotient), 64'(e[31:0]));
        check({tag, " div_by_zero"}, 64'(bus.div_by_zero), 64'(e[33]));
        check({tag, " overflow"}, 64'(bus.overflow), 64'(e[32]));
        check({tag, " busy_while_running"}, 64'(busy_ok), 64'd1);
        check({tag, " busy_at_done"}, 64'(bus.busy), 64'd0);
        $display("div %s: %h / %h -> %h dbz=%b ovf=%b lat=%0d",
                 tag, a, b, bus.quotient, bus.div_by_zero, bus.overflow, lat);
    endtask

    initial begin
        int          lat;
        int          n_done;
        logic        busy_ok;
        logic [31:0] a, b, q_seen;

        reset = 1'b1;
        bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset quotient", 64'(bus.quotient), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset div_by_zero", 64'(bus.div_by_zero), 64'd0);
        check("reset overflow", 64'(bus.overflow), 64'd0);
        $display("reset: quotient=%h busy=%b done=%b", bus.quotient, bus.busy, bus.done);
        @(negedge clk);
        reset = 1'b0;

        // Directed cases, including the fixed expectations from the design notes.
        run_div(32'h0000_1800, 32'h0000_0800, "6/2");
        check("6/2 const", 64'(bus.quotient), 64'h0000_0C00);
        run_div(32'h0000_0400, 32'h0000_0C00, "1/3");
        check("1/3 const", 64'(bus.quotient), 64'h0000_0155);
        run_div(32'hFFFF_FC00, 32'h0000_0C00, "-1/3");
        check("-1/3 const", 64'(bus.quotient), 64'hFFFF_FEAB);
        run_div(32'hFFFF_E200, 32'h0000_0800, "-7.5/2");
        check("-7.5/2 const", 64'(bus.quotient), 64'hFFFF_F100);
        run_div(32'h8000_0000, 32'hFFFF_FC00, "minneg/-1");
        check("minneg/-1 const", 64'({bus.overflow, bus.quotient}), 64'h1_7FFF_FFFF);
        run_div(32'h8000_0000, 32'h0000_0400, "minneg/1");
        run_div(32'h8000_0000, 32'h8000_0000, "minneg/minneg");
        run_div(32'h7FFF_FFFF, 32'h0000_0001, "max/eps");
        run_div(32'h0000_0400, 32'h0000_0000, "pos/0");
        check("pos/0 const", 64'(bus.quotient), 64'h7FFF_FFFF);
        run_div(32'hFFFF_FC00, 32'h0000_0000, "neg/0");
        check("neg/0 const", 64'(bus.quotient), 64'h8000_0000);
        run_div(32'h0000_0000, 32'h0000_0000, "0/0");
        check("0/0 const", 64'(bus.quotient), 64'h0);

        for (int i = 0; i < 24; i++) begin
            a = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) a = -a;
            b = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) b = -b;
            if (i % 8 == 7) b = 32'h0;
            run_div(a, b, $sformatf("rand%0d", i));
        end

        // A start pulse during ITER must be dropped, not queued.
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 32'h0000_1800; bus.divisor = 32'h0000_0800;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 32'h0000_0400; bus.divisor = 32'h0;
        @(negedge clk);
        bus.start = 1'b0;
        n_done = 0;
        q_seen = '0;
        for (int i = 0; i < 150; i++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                n_done++;
                q_seen = bus.quotient;
            end
        end
        check("ignored start done count", 64'(n_done), 64'd1);
        check("ignored start quotient", 64'(q_seen), 64'h0000_0C00);
        $display("ignored-start: dones=%0d quotient=%h", n_done, q_seen);

        // Start held high through done launches the next divide immediately.
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 32'hFFFF_E200; bus.divisor = 32'h0000_0800;
        @(posedge clk); #1;
        bus.dividend = 32'h0000_1800; bus.divisor = 32'h0000_0800;
        wait_done(lat, busy_ok);
        check("b2b first latency", 64'(lat), 64'd44);
        check("b2b first quotient", 64'(bus.quotient), 64'hFFFF_F100);
        @(posedge clk); #1;
        check("b2b busy after done", 64'(bus.busy), 64'd1);
        check("b2b done low", 64'(bus.done), 64'd0);
        bus.start = 1'b0;
        wait_done(lat, busy_ok);
        check("b2b second latency", 64'(lat), 64'd44);
        check("b2b second quotient", 64'(bus.quotient), 64'h0000_0C00);
        $display("back-to-back: second quotient=%h lat=%0d", bus.quotient, lat);

        // Asynchronous reset in the middle of ITER aborts without a done pulse.
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 32'h0000_0400; bus.divisor = 32'h0000_0C00;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (21) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midreset quotient", 64'(bus.quotient), 64'd0);
        check("midreset busy", 64'(bus.busy), 64'd0);
        check("midreset done", 64'(bus.done), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n_done = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (bus.done) n_done++;
        end
        check("midreset no done", 64'(n_done), 64'd0);
        $display("mid-reset: dones after abort=%0d", n_done);
        run_div(32'h0000_1800, 32'h0000_0800, "6/2 after reset");
        check("6/2 after reset const", 64'(bus.quotient), 64'h0000_0C00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fxp_divider.md
Name: fxp_divider

Overview:
- Sequential signed fixed-point divider, the inverse companion to the fixed-point multiplier in the execute-stage fixed-point unit.
- Computes quotient = (dividend << FBITS) / divisor in Q(WIDTH-FBITS).FBITS two's-complement format, one radix-2 restoring step per cycle.
- Uses a start/busy/done handshake so the fixed-point unit can issue a divide and stall until done.

Parameters:
- WIDTH, 32, operand and result width in bits.
- FBITS, 10, number of fractional bits; 1.0 = 1 << FBITS.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- dividend  input  WIDTH  signed fixed-point numerator; sampled with start.
- divisor  input  WIDTH  signed fixed-point denominator; sampled with start.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; quotient and flags are valid.
- quotient  output  WIDTH  signed fixed-point result, registered.
- div_by_zero  output  1  divisor was 0; valid with done.
- overflow  output  1  result saturated; valid with done.

Behaviour:
- Reset (async, immediate): state=IDLE; busy=0, done=0, quotient=0, div_by_zero=0, overflow=0; all internal registers cleared. Reset mid-operation aborts with no done pulse.
- FSM states: IDLE, PREP, ITER, FIX.
- IDLE: on start=1, latch operands and go to PREP. start while busy is ignored, with no queueing.
- PREP (1 cycle):
  - Record the signs; result sign = sign(dividend) XOR sign(divisor).
  - Take absolute values as WIDTH-bit unsigned. Most-negative input maps to 2^(WIDTH-1), which is legal.
  - If divisor==0, go to FIX with the dbz flag set. Otherwise load numerator magnitude << FBITS (WIDTH+FBITS bits) and clear remainder (WIDTH+1 bits) and counter, then go to ITER.
- ITER (exactly WIDTH+FBITS cycles, counter 0..WIDTH+FBITS-1):
  - Shift remainder left, bringing in the numerator MSB.
  - Subtract |divisor|. If non-negative, keep the difference and shift in quotient bit 1; else restore and shift in 0.
  - After the last step, go to FIX.
- FIX (1 cycle), registers the outputs and sets done=1 for that next cycle, then returns to IDLE:
  - Magnitude is truncated (rounding toward zero). Negate the magnitude if result sign is negative.
  - Positive result with magnitude > 2^(WIDTH-1)-1: quotient = 0x7FFFFFFF, overflow=1.
  - Negative result with magnitude > 2^(WIDTH-1): quotient = 0x80000000, overflow=1.
  - Divide by zero: dividend>0 gives 0x7FFFFFFF; dividend<0 gives 0x80000000; dividend==0 gives 0. div_by_zero=1, overflow=0.
- Latency: start accepted at edge 0 gives done high after edge WIDTH+FBITS+2 (44 cycles at defaults). Divide-by-zero gives done after edge 2.
- busy: 1 in PREP, ITER and FIX; 0 in IDLE. done and busy are never high together.
- Back-to-back: start high in the done cycle is accepted (state is IDLE).
- Holding: quotient and flags hold until the next FIX write. Flags are cleared when a new start is accepted.

Test Plan:
- 6.0/2.0: dividend 0x00001800, divisor 0x00000800 -> quotient 0x00000C00 (3.0), flags 0, done exactly 44 cycles after start edge.
- 1.0/3.0: 0x00000400 / 0x00000C00 -> 0x00000155 (truncated). -1.0/3.0 -> 0xFFFFFEAB (toward zero).
- -7.5/2.0: 0xFFFFE200 / 0x00000800 -> 0xFFFFF100 (-3.75). 0x80000000 / 0xFFFFFC00 (-1.0) -> 0x7FFFFFFF, overflow=1.
- Divide by zero: 0x00000400/0 -> 0x7FFFFFFF. 0xFFFFFC00/0 -> 0x80000000. 0/0 -> 0. All with div_by_zero=1 and done 2 cycles after start.
- Handshake: start pulsed during ITER is ignored, giving one done only. start held high through done launches a second divide immediately, with busy=1 the next cycle.
- Reset asserted at ITER cycle 20: outputs go to 0 at once, no done pulse. A fresh 6.0/2.0 afterwards gives 0x00000C00.
